// File: rtl/vedic_mult8_seq_if.sv
// Operand/product handshake bundle for vedic_mult8_seq: valid/ready on the operand
// side and on the product side.
interface vedic_mult8_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/vedic_mult8_seq.sv
// Multi-cycle 8x8 unsigned Vedic (Urdhva) multiplier: four 4x4 partial products
// accumulated one nibble per cycle through a single shared 4-bit add slice.
module vedic_mult8_seq #(
   parameter int SKIP_ZERO = 1,
   parameter int COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   vedic_mult8_seq_if.slave   bus,
   output logic               busy,
   output logic [COUNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [7:0]         a_q, a_d;
   logic [7:0]         b_q, b_d;
   logic [15:0]        acc_q, acc_d;
   logic               carry_q, carry_d;
   logic [2:0]         step_q, step_d;
   logic [15:0]        product_q, product_d;
   logic               out_valid_q, out_valid_d;
   logic [COUNT_W-1:0] ops_done_q, ops_done_d;

   logic [3:0]  mx, my;
   logic [7:0]  pp;
   logic [1:0]  nib;
   logic [3:0]  op_nib;
   logic        first;
   logic [3:0]  acc_nib;
   logic [4:0]  sum;
   logic [15:0] acc_add;

   function automatic logic [4:0] add4(input logic [3:0] x, input logic [3:0] y,
                                       input logic cin);
      return {1'b0, x} + {1'b0, y} + {4'd0, cin};
   endfunction

   always_comb begin
      // One 4x4 product is formed per cycle from whichever nibble pair the pass needs
      mx = a_q[3:0];
      my = b_q[3:0];
      if (state_q == S_ADD) begin
         case (step_q)
            3'd0, 3'd1, 3'd2: begin mx = a_q[7:4]; my = b_q[3:0]; end
            3'd3, 3'd4, 3'd5: begin mx = a_q[3:0]; my = b_q[7:4]; end
            default:          begin mx = a_q[7:4]; my = b_q[7:4]; end
         endcase
      end
      pp = {4'd0, mx} * {4'd0, my};

      nib    = 2'd1;
      op_nib = pp[3:0];
      first  = 1'b1;
      case (step_q)
         3'd0: begin nib = 2'd1; op_nib = pp[3:0]; first = 1'b1; end
         3'd1: begin nib = 2'd2; op_nib = pp[7:4]; first = 1'b0; end
         3'd2: begin nib = 2'd3; op_nib = 4'd0;    first = 1'b0; end
         3'd3: begin nib = 2'd1; op_nib = pp[3:0]; first = 1'b1; end
         3'd4: begin nib = 2'd2; op_nib = pp[7:4]; first = 1'b0; end
         3'd5: begin nib = 2'd3; op_nib = 4'd0;    first = 1'b0; end
         3'd6: begin nib = 2'd2; op_nib = pp[3:0]; first = 1'b1; end
         default: begin nib = 2'd3; op_nib = pp[7:4]; first = 1'b0; end
      endcase

      acc_nib = acc_q[{nib, 2'b00} +: 4];
      sum     = add4(acc_nib, op_nib, first ? 1'b0 : carry_q);
      acc_add = acc_q;
      acc_add[{nib, 2'b00} +: 4] = sum[3:0];

      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      step_d      = step_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;
      ops_done_d  = ops_done_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            carry_d = 1'b0;
            step_d  = 3'd0;
            if ((SKIP_ZERO != 0) && ((a_q == 8'd0) || (b_q == 8'd0))) begin
               acc_d   = 16'd0;
               state_d = S_DONE;
            end else begin
               acc_d   = {8'd0, pp};
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            acc_d   = acc_add;
            carry_d = sum[4];
            step_d  = step_q + 3'd1;
            if (step_q == 3'd7) begin
               product_d   = acc_add;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         default: begin
            // Zero-skip arrives here without a product yet; publish it on the next edge
            if (!out_valid_q) begin
               product_d   = acc_q;
               out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               ops_done_d  = ops_done_q + COUNT_W'(1);
               state_d     = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         acc_q       <= 16'd0;
         carry_q     <= 1'b0;
         step_q      <= 3'd0;
         product_q   <= 16'd0;
         out_valid_q <= 1'b0;
         ops_done_q  <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         step_q      <= step_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign busy          = (state_q == S_LOAD) || (state_q == S_ADD);
   assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_vedic_mult8_seq.sv
// Randomized self-checking bench for vedic_mult8_seq: three instances (zero-skip,
// full sequence, narrow counter) checked against a plain a*b model.
module tb_vedic_mult8_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0]  iv   = '0;
   logic [2:0]  ordy = '0;
   logic [7:0]  ta [3];
   logic [7:0]  tbv [3];
   logic [2:0]  ir, ov, bsy;
   logic [15:0] prod [3];
   logic [15:0] od [3];
   logic [15:0] od0, od1;
   logic [3:0]  od2;
   int          od_model [3];
   int          od_mask  [3];

   vedic_mult8_seq_if bus0 ();
   vedic_mult8_seq_if bus1 ();
   vedic_mult8_seq_if bus2 ();

   vedic_mult8_seq #(.SKIP_ZERO(1), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(bsy[0]), .ops_done(od0));
   vedic_mult8_seq #(.SKIP_ZERO(0), .COUNT_W(16)) dut_noskip (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(bsy[1]), .ops_done(od1));
   vedic_mult8_seq #(.SKIP_ZERO(1), .COUNT_W(4)) dut_c4 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(bsy[2]), .ops_done(od2));

   assign bus0.in_valid = iv[0];   assign bus0.out_ready = ordy[0];
   assign bus0.a = ta[0];          assign bus0.b = tbv[0];
   assign ir[0] = bus0.in_ready;   assign ov[0] = bus0.out_valid;
   assign prod[0] = bus0.product;  assign od[0] = od0;

   assign bus1.in_valid = iv[1];   assign bus1.out_ready = ordy[1];
   assign bus1.a = ta[1];          assign bus1.b = tbv[1];
   assign ir[1] = bus1.in_ready;   assign ov[1] = bus1.out_valid;
   assign prod[1] = bus1.product;  assign od[1] = od1;

   assign bus2.in_valid = iv[2];   assign bus2.out_ready = ordy[2];
   assign bus2.a = ta[2];          assign bus2.b = tbv[2];
   assign ir[2] = bus2.in_ready;   assign ov[2] = bus2.out_valid;
   assign prod[2] = bus2.product;  assign od[2] = {12'd0, od2};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Issue one operation on instance d, optionally stall the consumer for 'hold'
   // cycles while offering a fresh operand pair, then hand the product off.
   task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y, input int hold);
      int          lat, bcnt, waitc;
      bit          skip;
      logic [15:0] exp_p;
      skip  = (d != 1) && ((x == 8'd0) || (y == 8'd0));
      exp_p = 16'(x) * 16'(y);
      waitc = 0;
      while (!ir[d] && waitc < 50) begin @(posedge clk); #1; waitc++; end
      check("in_ready_before_accept", 32'(ir[d]), 32'd1);
      iv[d] = 1'b1; ta[d] = x; tbv[d] = y;
      @(posedge clk); #1;
      iv[d] = 1'b0; ta[d] = 8'($urandom); tbv[d] = 8'($urandom);
      lat = 0; bcnt = 0;
      while (!ov[d] && lat < 40) begin
         if (bsy[d]) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), skip ? 32'd2 : 32'd9);
      check("busy_cycles", 32'(bcnt), skip ? 32'd1 : 32'd9);
      check("product", 32'(prod[d]), 32'(exp_p));
      if (hold > 0) begin
         iv[d] = 1'b1;
         repeat (hold) begin
            ta[d] = 8'($urandom); tbv[d] = 8'($urandom);
            @(posedge clk); #1;
            check("hold_product", 32'(prod[d]), 32'(exp_p));
            check("hold_in_ready", 32'(ir[d]), 32'd0);
            check("hold_out_valid", 32'(ov[d]), 32'd1);
         end
         iv[d] = 1'b0;
      end
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      ordy[d] = 1'b0;
      od_model[d] = (od_model[d] + 1) & od_mask[d];
      check("out_valid_drop", 32'(ov[d]), 32'd0);
      check("ops_done", 32'(od[d]), 32'(od_model[d]));
      check("idle_in_ready", 32'(ir[d]), 32'd1);
      check("product_hold_idle", 32'(prod[d]), 32'(exp_p));
      if (hold > 0) begin
         repeat (3) begin
            @(posedge clk); #1;
            check("no_queued_op", 32'(bsy[d]), 32'd0);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         ta[i] = 8'd0; tbv[i] = 8'd0; od_model[i] = 0;
      end
      od_mask[0] = 16'hFFFF; od_mask[1] = 16'hFFFF; od_mask[2] = 4'hF;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(ir[0]), 32'd1);
      check("rst_out_valid", 32'(ov[0]), 32'd0);
      check("rst_busy", 32'(bsy[0]), 32'd0);
      check("rst_product", 32'(prod[0]), 32'd0);
      check("rst_ops_done", 32'(od[0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(0, 8'hFF, 8'hFF, 0);
      run_op(0, 8'h12, 8'h34, 0);
      run_op(0, 8'h80, 8'h02, 0);
      run_op(0, 8'h0F, 8'hF0, 0);
      run_op(0, 8'h00, 8'hAB, 0);
      run_op(0, 8'hAB, 8'h00, 0);
      run_op(0, 8'h5A, 8'h3C, 5);
      for (int i = 0; i < 6; i++) run_op(0, 8'($urandom), 8'($urandom), 0);

      // Abort an operation in the middle of ADD with an asynchronous reset
      iv[0] = 1'b1; ta[0] = 8'h77; tbv[0] = 8'h99;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midop_busy_before_rst", 32'(bsy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midop_rst_busy", 32'(bsy[0]), 32'd0);
      check("midop_rst_out_valid", 32'(ov[0]), 32'd0);
      check("midop_rst_in_ready", 32'(ir[0]), 32'd1);
      check("midop_rst_product", 32'(prod[0]), 32'd0);
      check("midop_rst_ops_done", 32'(od[0]), 32'd0);
      for (int i = 0; i < 3; i++) od_model[i] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(0, 8'h0A, 8'h0B, 0);

      run_op(1, 8'h00, 8'hAB, 0);
      run_op(1, 8'hFF, 8'hFF, 0);
      for (int i = 0; i < 4; i++) run_op(1, 8'($urandom), 8'($urandom), 0);

      for (int i = 0; i < 17; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i == 3) ra = 8'h00;
         if (i == 9) rb = 8'h00;
         run_op(2, ra, rb, 0);
      end
      check("count4_wrapped", 32'(od[2]), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
